// File: rtl/bilbo_bist_engine.sv
// Parametrised BILBO register: functional/scan/PRPG/MISR modes with a counted
// self-test session and golden-signature comparison.
module bilbo_bist_engine #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             scan_in,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] q,
  output logic             scan_out,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'd0,
    M_LOAD  = 3'd1,
    M_SHIFT = 3'd2,
    M_PRPG  = 3'd3,
    M_MISR  = 3'd4,
    M_CLEAR = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state, next_state;
  mode_e            sess_mode, step_mode;
  logic [CNT_W-1:0] cnt;
  logic             accept, finish, dec_cnt;
  logic             fb;
  logic [WIDTH-1:0] shifted, q_next;

  function automatic mode_e decode(input logic [2:0] m);
    case (m)
      3'd1:    return M_LOAD;
      3'd2:    return M_SHIFT;
      3'd3:    return M_PRPG;
      3'd4:    return M_MISR;
      3'd5:    return M_CLEAR;
      default: return M_HOLD;
    endcase
  endfunction

  // The done pulse follows the DONE state by one cycle; that cycle still counts
  // as busy, so q holds and start is ignored until it has passed.
  always_comb begin
    next_state = state;
    step_mode  = M_HOLD;
    accept     = 1'b0;
    finish     = 1'b0;
    dec_cnt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!done) begin
          if (start && (mode == M_PRPG || mode == M_MISR)) begin
            accept     = 1'b1;
            next_state = (num_patterns == '0) ? S_DONE : S_RUN;
          end else begin
            step_mode = decode(mode);
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          next_state = S_IDLE;
        end else begin
          step_mode = sess_mode;
          dec_cnt   = 1'b1;
          if (cnt == CNT_W'(1)) next_state = S_DONE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
        finish     = !abort;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign fb      = ^(q & POLY);
  assign shifted = {q[WIDTH-2:0], fb};

  always_comb begin
    q_next = q;
    case (step_mode)
      M_LOAD:  q_next = d;
      M_SHIFT: q_next = {q[WIDTH-2:0], scan_in};
      M_PRPG:  q_next = (q == '0) ? SEED : shifted;
      M_MISR:  q_next = shifted ^ d;
      M_CLEAR: q_next = '0;
      default: q_next = q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      q         <= '0;
      cnt       <= '0;
      sess_mode <= M_PRPG;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state <= next_state;
      q     <= q_next;
      done  <= finish;
      if (accept) begin
        sess_mode <= decode(mode);
        cnt       <= num_patterns;
        pass      <= 1'b0;
      end else begin
        if (dec_cnt) cnt <= cnt - CNT_W'(1);
        if (finish) pass <= (q == golden);
      end
    end
  end

  assign scan_out = q[WIDTH-1];
  assign busy     = (state != S_IDLE) || done;

endmodule

// File: tb/tb_bilbo_bist_engine.sv
// Self-checking bench for bilbo_bist_engine: directed test-plan items plus
// randomized free-running modes and sessions against an arithmetic model.
module tb_bilbo_bist_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic [7:0]  d;
  logic        scan_in, start, abort;
  logic [15:0] num_patterns;
  logic [7:0]  golden;
  logic [7:0]  q;
  logic        scan_out, busy, done, pass;

  logic [2:0]  mode4;
  logic [3:0]  d4, golden4, q4;
  logic        scan_in4, start4, abort4;
  logic [15:0] num_patterns4;
  logic        scan_out4, busy4, done4, pass4;

  int checks = 0;
  int errors = 0;
  int mq = 0;
  int m4 = 0;

  always #5 clk = ~clk;

  bilbo_bist_engine dut (
    .clk(clk), .rst(rst), .mode(mode), .d(d), .scan_in(scan_in),
    .start(start), .abort(abort), .num_patterns(num_patterns), .golden(golden),
    .q(q), .scan_out(scan_out), .busy(busy), .done(done), .pass(pass)
  );

  bilbo_bist_engine #(.WIDTH(4), .POLY(4'hC), .SEED(4'h1), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .mode(mode4), .d(d4), .scan_in(scan_in4),
    .start(start4), .abort(abort4), .num_patterns(num_patterns4), .golden(golden4),
    .q(q4), .scan_out(scan_out4), .busy(busy4), .done(done4), .pass(pass4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Next register value from the mode table, using integer shift/parity arithmetic.
  function automatic int ref_next(int w, int poly, int seed, int m, int cur, int din, int sin);
    int md = 1 << w;
    int sh = (cur * 2) % md;
    int par = $countones(cur & poly) % 2;
    case (m)
      1: return din % md;
      2: return sh + sin;
      3: return (cur == 0) ? seed : sh + par;
      4: return (sh + par) ^ (din % md);
      5: return 0;
      default: return cur;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_free(input int m, input int dv, input int s);
    mode = 3'(m);
    d = 8'(dv);
    scan_in = s[0];
    tick();
    mq = ref_next(8, 'hB8, 1, m, mq, dv % 256, s % 2);
    chk("free_q", q, mq);
    chk("free_scan_out", scan_out, (mq >> 7) & 1);
    chk("free_busy", busy, 0);
  endtask

  // dsel: 0 random d, 1 d equals the step number. gsel: -1 model signature,
  // -2 random golden, otherwise the literal golden value.
  task automatic session(input int m, input int n, input int abort_at, input int dsel, input int gsel);
    int dv;
    int exp_pass;
    mode = 3'(m);
    start = 1'b1;
    num_patterns = 16'(n);
    abort = 1'b0;
    golden = 8'($urandom);
    tick();
    chk("sess_busy_start", busy, 1);
    chk("sess_pass_clr", pass, 0);
    chk("sess_q_start", q, mq);
    chk("sess_done_start", done, 0);
    start = 1'($urandom);
    mode = 3'($urandom);
    for (int k = 1; k <= n; k++) begin
      dv = (dsel == 1) ? k : int'($urandom % 256);
      d = 8'(dv);
      tick();
      mq = ref_next(8, 'hB8, 1, m, mq, dv, 0);
      chk("sess_step_q", q, mq);
      chk("sess_step_busy", busy, 1);
      chk("sess_step_done", done, 0);
      if (k == abort_at) begin
        abort = 1'b1;
        d = 8'($urandom);
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", q, mq);
        chk("abort_pass", pass, 0);
        abort = 1'b0;
        start = 1'b0;
        mode = 3'd0;
        tick();
        chk("abort_after_done", done, 0);
        chk("abort_after_q", q, mq);
        return;
      end
    end
    if (gsel == -1) golden = 8'(mq);
    else if (gsel >= 0) golden = 8'(gsel);
    exp_pass = (int'(golden) == mq) ? 1 : 0;
    d = 8'($urandom);
    tick();
    chk("sess_done_pulse", done, 1);
    chk("sess_pass", pass, exp_pass);
    chk("sess_busy_done", busy, 1);
    chk("sess_q_done", q, mq);
    mode = 3'd0;
    start = 1'b0;
    golden = 8'($urandom);
    tick();
    chk("sess_done_low", done, 0);
    chk("sess_busy_low", busy, 0);
    chk("sess_pass_hold", pass, exp_pass);
    chk("sess_q_end", q, mq);
  endtask

  initial begin
    int walk[5];
    int bits[8];
    walk = '{'h02, 'h04, 'h08, 'h11, 'h23};
    bits = '{1, 0, 1, 1, 0, 0, 0, 0};
    rst = 1'b1; mode = 3'd0; d = '0; scan_in = 1'b0; start = 1'b0; abort = 1'b0;
    num_patterns = '0; golden = '0;
    mode4 = 3'd0; d4 = '0; golden4 = '0; scan_in4 = 1'b0; start4 = 1'b0; abort4 = 1'b0;
    num_patterns4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 0);
    chk("rst_scan_out", scan_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    rst = 1'b0;

    run_free(1, 'h01, 0);
    for (int i = 0; i < 5; i++) begin
      run_free(3, 0, 0);
      chk("prpg_walk", q, walk[i]);
    end
    run_free(1, 0, 0);
    run_free(3, 0, 0);
    chk("prpg_seed", q, 1);
    run_free(1, 'h01, 0);
    for (int i = 0; i < 255; i++) run_free(3, int'($urandom % 256), 0);
    chk("prpg_period", q, 1);

    run_free(5, 0, 0);
    for (int i = 0; i < 8; i++) run_free(2, 0, bits[i]);
    chk("shift_b0", q, 'hB0);

    mode = 3'd1; d = 8'h3C; start = 1'b1; num_patterns = 16'd4;
    tick();
    mq = 'h3C;
    chk("start_load_q", q, 'h3C);
    chk("start_load_busy", busy, 0);
    start = 1'b0;

    for (int i = 0; i < 150; i++) begin
      int m = int'($urandom % 8);
      start = (m == 3 || m == 4) ? 1'b0 : 1'($urandom);
      num_patterns = 16'($urandom % 4);
      run_free(m, int'($urandom % 256), int'($urandom % 2));
    end
    start = 1'b0;

    run_free(5, 0, 0);
    session(4, 2, 0, 1, 'h00);
    chk("misr_sig", q, 'h00);
    run_free(5, 0, 0);
    session(4, 2, 0, 1, 'h5A);
    chk("misr_fail_pass", pass, 0);

    run_free(1, 'h77, 0);
    session(3, 0, 0, 0, -1);
    chk("n0_q_unchanged", q, 'h77);
    session(3, 10, 3, 0, -2);
    for (int i = 0; i < 12; i++) begin
      int n = int'($urandom % 6);
      int ab = (n > 1 && ($urandom % 4) == 0) ? int'(1 + $urandom % (n - 1)) : 0;
      session(3 + int'($urandom % 2), n, ab, 0, ($urandom % 2) ? -1 : -2);
    end

    mode = 3'd3; start = 1'b1; num_patterns = 16'd10;
    tick();
    start = 1'b0; mode = 3'd0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_q", q, 0);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_pass", pass, 0);
    @(negedge clk);
    rst = 1'b0;
    mq = 0;
    tick();
    chk("post_rst_done", done, 0);
    chk("post_rst_q", q, 0);

    mode4 = 3'd1; d4 = 4'h1;
    tick();
    m4 = 1;
    chk("w4_load", q4, 1);
    mode4 = 3'd3;
    for (int i = 0; i < 15; i++) begin
      tick();
      m4 = ref_next(4, 'hC, 1, 3, m4, 0, 0);
      chk("w4_prpg", q4, m4);
      chk("w4_nonzero", (q4 == 4'h0) ? 1 : 0, 0);
    end
    chk("w4_period", q4, 1);
    mode4 = 3'd1; d4 = 4'h0;
    tick();
    mode4 = 3'd3;
    tick();
    chk("w4_seed", q4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
